// File: rtl/recorder_controller.sv
// recorder_controller: sequences the voice-recorder datapath.
// Record moves deserializer words into the selected BRAM block and remembers
// how many were stored. Playback streams that block back to the serializer,
// optionally looping. All outputs are registered; reset is synchronous and
// active-low.
module recorder_controller #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 50000,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              record,
    input  logic              play,
    input  logic              switch0,
    input  logic              switch1,
    input  logic              des_done,
    input  logic [DATA_W-1:0] des_data,
    input  logic              ser_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ser_load,
    output logic [DATA_W-1:0] ser_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              block1_ena,
    output logic              block1_wea,
    output logic              block2_ena,
    output logic              block2_wea,
    output logic              recording,
    output logic              playing,
    output logic [1:0]        mode
);

    // A full block holds DEPTH words, and DEPTH may equal 2^ADDR_W, so the
    // stored lengths need one bit more than an address.
    localparam int                LEN_W     = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [LEN_W-1:0]  FULL_LEN  = LEN_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REC,
        S_REC_FULL,
        S_PLAY_RD,
        S_PLAY_WAIT,
        S_PLAY_LOAD
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   addr, addr_n;
    logic                sel, sel_n;
    logic [LEN_W-1:0]    len1, len1_n;
    logic [LEN_W-1:0]    len2, len2_n;
    logic                wr_pend, wr_pend_n;
    logic                play_q;
    logic                play_rise;
    logic [LEN_W-1:0]    len_cur;
    logic [LEN_W-1:0]    len_req;
    logic [LEN_W-1:0]    addr_plus1;
    logic                acc_en, acc_we;
    logic [ADDR_W-1:0]   mem_addr_n;
    logic [DATA_W-1:0]   mem_wdata_n;
    logic [DATA_W-1:0]   ser_data_n;
    logic                ser_load_n;
    logic [1:0]          mode_n;

    assign play_rise  = play & ~play_q;
    // Length of the block being operated on (latched select) and of the block
    // the user is currently pointing at (live switch), used to refuse empty play.
    assign len_cur    = sel ? len2 : len1;
    assign len_req    = switch0 ? len2 : len1;
    assign addr_plus1 = {1'b0, addr} + LEN_W'(1);

    // State register.
    // NOTE: every clocked process uses non-blocking (<=) assignments so all
    // registers update from the same pre-edge values; blocking (=) here would
    // make the result depend on statement order.
    always_ff @(posedge clock) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state, bookkeeping and next-output logic.
    // NOTE: every signal written in this block receives a default first, so no
    // path through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n     = state;
        addr_n      = addr;
        sel_n       = sel;
        len1_n      = len1;
        len2_n      = len2;
        wr_pend_n   = 1'b0;
        acc_en      = 1'b0;
        acc_we      = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        ser_load_n  = 1'b0;
        ser_data_n  = ser_data;

        unique case (state)
            S_IDLE: begin
                // Record wins over a simultaneous play edge.
                if (record) begin
                    sel_n   = switch0;
                    addr_n  = '0;
                    state_n = S_REC;
                end else if (play_rise && (len_req != '0)) begin
                    sel_n      = switch0;
                    addr_n     = '0;
                    acc_en     = 1'b1;
                    mem_addr_n = '0;
                    state_n    = S_PLAY_RD;
                end
            end

            S_REC: begin
                if (wr_pend) begin
                    // The write to addr is on the bus this cycle.
                    if (addr == LAST_ADDR) begin
                        if (sel) len2_n = FULL_LEN;
                        else     len1_n = FULL_LEN;
                        state_n = S_REC_FULL;
                    end else begin
                        addr_n = addr + ADDR_W'(1);
                        if (des_done) begin
                            acc_en      = 1'b1;
                            acc_we      = 1'b1;
                            mem_addr_n  = addr + ADDR_W'(1);
                            mem_wdata_n = des_data;
                            wr_pend_n   = 1'b1;
                        end
                    end
                end else if (des_done) begin
                    acc_en      = 1'b1;
                    acc_we      = 1'b1;
                    mem_addr_n  = addr;
                    mem_wdata_n = des_data;
                    wr_pend_n   = 1'b1;
                end else if (!record) begin
                    // The button level only matters once no word is in flight,
                    // so a word that lands on the release cycle is still kept.
                    if (sel) len2_n = {1'b0, addr};
                    else     len1_n = {1'b0, addr};
                    state_n = S_IDLE;
                end
            end

            S_REC_FULL: begin
                // Require a release so a held button cannot start a new take.
                if (!record) state_n = S_IDLE;
            end

            S_PLAY_RD: begin
                state_n = S_PLAY_WAIT;
            end

            S_PLAY_WAIT: begin
                ser_data_n = mem_rdata;
                state_n    = S_PLAY_LOAD;
            end

            S_PLAY_LOAD: begin
                if (ser_ready) begin
                    ser_load_n = 1'b1;
                    if (addr_plus1 == len_cur) begin
                        if (switch1) begin
                            addr_n     = '0;
                            acc_en     = 1'b1;
                            mem_addr_n = '0;
                            state_n    = S_PLAY_RD;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        addr_n     = addr + ADDR_W'(1);
                        acc_en     = 1'b1;
                        mem_addr_n = addr + ADDR_W'(1);
                        state_n    = S_PLAY_RD;
                    end
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Display mode code follows the state being entered.
    always_comb begin
        mode_n = 2'd0;
        unique case (state_n)
            S_REC:                               mode_n = 2'd1;
            S_REC_FULL:                          mode_n = 2'd3;
            S_PLAY_RD, S_PLAY_WAIT, S_PLAY_LOAD: mode_n = 2'd2;
            default:                             mode_n = 2'd0;
        endcase
    end

    // Bookkeeping registers and registered outputs; only the latched block's
    // enables are ever driven.
    always_ff @(posedge clock) begin
        if (!reset) begin
            addr       <= '0;
            sel        <= 1'b0;
            len1       <= '0;
            len2       <= '0;
            wr_pend    <= 1'b0;
            play_q     <= 1'b0;
            ser_load   <= 1'b0;
            ser_data   <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            block1_ena <= 1'b0;
            block1_wea <= 1'b0;
            block2_ena <= 1'b0;
            block2_wea <= 1'b0;
            recording  <= 1'b0;
            playing    <= 1'b0;
            mode       <= 2'd0;
        end else begin
            addr       <= addr_n;
            sel        <= sel_n;
            len1       <= len1_n;
            len2       <= len2_n;
            wr_pend    <= wr_pend_n;
            play_q     <= play;
            ser_load   <= ser_load_n;
            ser_data   <= ser_data_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            block1_ena <= acc_en & ~sel_n;
            block1_wea <= acc_en & acc_we & ~sel_n;
            block2_ena <= acc_en & sel_n;
            block2_wea <= acc_en & acc_we & sel_n;
            recording  <= (state_n == S_REC);
            playing    <= (state_n == S_PLAY_RD) || (state_n == S_PLAY_WAIT) ||
                          (state_n == S_PLAY_LOAD);
            mode       <= mode_n;
        end
    end

endmodule
